// File: rtl/imem_fetch_arb.sv
// Arbitrates the single combinational instruction memory between CPU fetch and a debug
// read-back port; CPU has priority, with a starvation counter forcing debug through.
module imem_fetch_arb #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              im_r,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [DATA_W-1:0] im_data
);

    typedef enum logic [1:0] {
        IDLE,
        CPU_RD,
        DBG_RD
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state;
    logic [3:0]        starve_cnt;
    logic [ADDR_W-1:0] last_addr;
    logic              force_dbg;

    // Grants are gated by rst_n so every output reads zero the moment reset asserts.
    always_comb begin
        force_dbg = dbg_req && (starve_cnt == STARVE_LIM);
        dbg_gnt   = rst_n && dbg_req && (!cpu_req || force_dbg);
        cpu_gnt   = rst_n && cpu_req && !dbg_gnt;
        im_r      = cpu_gnt || dbg_gnt;
        if (cpu_gnt) begin
            im_addr = cpu_addr;
        end else if (dbg_gnt) begin
            im_addr = dbg_addr;
        end else begin
            im_addr = last_addr;
        end
    end

    // State records last cycle's owner, so rvalid is simply a decode of it.
    assign cpu_rvalid = (state == CPU_RD);
    assign dbg_rvalid = (state == DBG_RD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            last_addr  <= '0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
        end else begin
            if (cpu_gnt) begin
                state     <= CPU_RD;
                cpu_rdata <= im_data;
            end else if (dbg_gnt) begin
                state     <= DBG_RD;
                dbg_rdata <= im_data;
            end else begin
                state <= IDLE;
            end
            if (im_r) begin
                last_addr <= im_addr;
            end
            // A waiting debug request can only lose to a CPU grant, so counting here is safe.
            if (!dbg_req || dbg_gnt) begin
                starve_cnt <= 4'd0;
            end else if (cpu_gnt && (starve_cnt != STARVE_LIM)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_arb.sv
// Directed bench for imem_fetch_arb: a memory model drives im_data and a per-requester
// scoreboard queue holds the read data expected one cycle after each grant.
module tb_imem_fetch_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic [10:0] cpu_addr = '0;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dbg_req = 1'b0;
    logic [10:0] dbg_addr = '0;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        im_r;
    logic [10:0] im_addr;
    logic [31:0] im_data;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] cpu_q[$];
    logic [31:0] dbg_q[$];
    logic [31:0] exp_cpu_rdata = '0;
    logic [31:0] exp_dbg_rdata = '0;
    logic [10:0] exp_last_addr = '0;

    imem_fetch_arb #(.ADDR_W(11), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .im_r(im_r), .im_addr(im_addr), .im_data(im_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [10:0] addr);
        return {19'b0, addr, 2'b00};
    endfunction

    assign im_data = mem_word(im_addr);

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive requests, check grants/IMEM bus, then check the registered return.
    task automatic apply_stimulus(input logic cr, input logic [10:0] ca,
                                  input logic dr, input logic [10:0] da,
                                  input logic ecg, input logic edg);
        cpu_req  = cr;
        cpu_addr = ca;
        dbg_req  = dr;
        dbg_addr = da;
        #1;
        check_output("cpu_gnt", 32'(cpu_gnt), 32'(ecg));
        check_output("dbg_gnt", 32'(dbg_gnt), 32'(edg));
        check_output("im_r", 32'(im_r), 32'(ecg | edg));
        if (ecg) exp_last_addr = ca;
        else if (edg) exp_last_addr = da;
        check_output("im_addr", 32'(im_addr), 32'(exp_last_addr));
        if (ecg) cpu_q.push_back(mem_word(ca));
        if (edg) dbg_q.push_back(mem_word(da));
        @(posedge clk);
        #1;
        if (ecg && cpu_q.size() > 0) exp_cpu_rdata = cpu_q.pop_front();
        if (edg && dbg_q.size() > 0) exp_dbg_rdata = dbg_q.pop_front();
        check_output("cpu_rvalid", 32'(cpu_rvalid), 32'(ecg));
        check_output("cpu_rdata", cpu_rdata, exp_cpu_rdata);
        check_output("dbg_rvalid", 32'(dbg_rvalid), 32'(edg));
        check_output("dbg_rdata", dbg_rdata, exp_dbg_rdata);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_cpu_gnt"}, 32'(cpu_gnt), 32'd0);
        check_output({tag, "_dbg_gnt"}, 32'(dbg_gnt), 32'd0);
        check_output({tag, "_im_r"}, 32'(im_r), 32'd0);
        check_output({tag, "_im_addr"}, 32'(im_addr), 32'd0);
        check_output({tag, "_cpu_rvalid"}, 32'(cpu_rvalid), 32'd0);
        check_output({tag, "_dbg_rvalid"}, 32'(dbg_rvalid), 32'd0);
        check_output({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
        check_output({tag, "_dbg_rdata"}, dbg_rdata, 32'd0);
    endtask

    initial begin
        // Power-on reset with both requests asserted: nothing may be granted.
        cpu_req = 1'b1;
        dbg_req = 1'b1;
        #1;
        check_reset_outputs("por");
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset asserted mid-grant with a read in flight.
        apply_stimulus(1'b1, 11'h005, 1'b0, 11'h000, 1'b1, 1'b0);
        cpu_addr = 11'h006;
        #1;
        check_output("midgrant_cpu_gnt", 32'(cpu_gnt), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        cpu_q.delete();
        dbg_q.delete();
        exp_cpu_rdata = '0;
        exp_dbg_rdata = '0;
        exp_last_addr = '0;
        cpu_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("post_reset_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        repeat (2) apply_stimulus(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0);

        // CPU-only streaming fetch.
        for (int i = 0; i < 4; i++)
            apply_stimulus(1'b1, 11'(i), 1'b0, 11'h000, 1'b1, 1'b0);

        // Simultaneous single request: CPU first, debug next cycle.
        apply_stimulus(1'b1, 11'h010, 1'b1, 11'h020, 1'b1, 1'b0);
        apply_stimulus(1'b0, 11'h000, 1'b1, 11'h020, 1'b0, 1'b1);
        apply_stimulus(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0);

        // Starvation: four CPU wins, then debug is forced, then CPU resumes.
        for (int i = 0; i < 4; i++)
            apply_stimulus(1'b1, 11'h100 + 11'(i), 1'b1, 11'h7FF, 1'b1, 1'b0);
        apply_stimulus(1'b1, 11'h104, 1'b1, 11'h7FF, 1'b0, 1'b1);
        apply_stimulus(1'b1, 11'h104, 1'b0, 11'h000, 1'b1, 1'b0);
        // Counter restarts from zero after a forced grant.
        for (int i = 0; i < 4; i++)
            apply_stimulus(1'b1, 11'h200 + 11'(i), 1'b1, 11'h0AA, 1'b1, 1'b0);
        apply_stimulus(1'b1, 11'h204, 1'b1, 11'h0AA, 1'b0, 1'b1);

        // Debug withdraw after three losses clears the counter.
        for (int i = 0; i < 3; i++)
            apply_stimulus(1'b1, 11'h300 + 11'(i), 1'b1, 11'h055, 1'b1, 1'b0);
        apply_stimulus(1'b1, 11'h303, 1'b0, 11'h000, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            apply_stimulus(1'b1, 11'h304 + 11'(i), 1'b1, 11'h066, 1'b1, 1'b0);
        apply_stimulus(1'b1, 11'h308, 1'b1, 11'h066, 1'b0, 1'b1);

        // Idle hold: address and read data stay put after the last grant.
        apply_stimulus(1'b1, 11'h123, 1'b0, 11'h000, 1'b1, 1'b0);
        repeat (5) apply_stimulus(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0);

        check_output("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
        check_output("dbg_q_drained", 32'(dbg_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
